// File: rtl/fpga_mul35_pipe.sv
// ============================================================================
// Module   : fpga_mul35_pipe
// Purpose  : Six-stage 35x35 unsigned multiplier built from four DSP-sized
//            partial products (18-bit low / 17-bit high operand halves).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpga_mul35_pipe #(
    parameter int A_W   = 35,
    parameter int B_W   = 35,
    parameter int SPLIT = 18,
    parameter int P_W   = 70
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [A_W-1:0] MUL_aa_a0,
    input  logic [B_W-1:0] MUL_bb_a0,
    output logic [P_W-1:0] MUL_mm_a6
);

    localparam int c_AHI_W = A_W - SPLIT;
    localparam int c_BHI_W = B_W - SPLIT;
    localparam int c_LL_W  = 2 * SPLIT;
    localparam int c_LH_W  = SPLIT + c_BHI_W;
    localparam int c_HL_W  = c_AHI_W + SPLIT;
    localparam int c_HH_W  = c_AHI_W + c_BHI_W;
    localparam int c_CR_W  = ((c_LH_W > c_HL_W) ? c_LH_W : c_HL_W) + 1;
    localparam int c_LO_W  = c_CR_W + SPLIT + 1;

    // Stage registers, named after the stage that owns them
    logic [A_W-1:0]     r_a1_a;
    logic [B_W-1:0]     r_a1_b;
    logic [c_LL_W-1:0]  r_a2_ll;
    logic [c_LH_W-1:0]  r_a2_lh;
    logic [c_HL_W-1:0]  r_a2_hl;
    logic [c_HH_W-1:0]  r_a2_hh;
    logic [c_LL_W-1:0]  r_a3_ll;
    logic [c_CR_W-1:0]  r_a3_cross;
    logic [c_HH_W-1:0]  r_a3_hh;
    logic [c_LO_W-1:0]  r_a4_low;
    logic [c_HH_W-1:0]  r_a4_hh;
    logic [P_W-1:0]     r_a5_full;
    logic [P_W-1:0]     r_a6_out;

    logic [SPLIT-1:0]   w_a_lo;
    logic [c_AHI_W-1:0] w_a_hi;
    logic [SPLIT-1:0]   w_b_lo;
    logic [c_BHI_W-1:0] w_b_hi;
    logic [c_LL_W-1:0]  w_pp_ll;
    logic [c_LH_W-1:0]  w_pp_lh;
    logic [c_HL_W-1:0]  w_pp_hl;
    logic [c_HH_W-1:0]  w_pp_hh;
    logic [c_CR_W-1:0]  w_cross;
    logic [c_LO_W-1:0]  w_low;
    logic [P_W-1:0]     w_full;

    assign w_a_lo = r_a1_a[SPLIT-1:0];
    assign w_a_hi = r_a1_a[A_W-1:SPLIT];
    assign w_b_lo = r_a1_b[SPLIT-1:0];
    assign w_b_hi = r_a1_b[B_W-1:SPLIT];

    // Operands widened to the product width so no partial product truncates
    assign w_pp_ll = c_LL_W'(w_a_lo) * c_LL_W'(w_b_lo);
    assign w_pp_lh = c_LH_W'(w_a_lo) * c_LH_W'(w_b_hi);
    assign w_pp_hl = c_HL_W'(w_a_hi) * c_HL_W'(w_b_lo);
    assign w_pp_hh = c_HH_W'(w_a_hi) * c_HH_W'(w_b_hi);

    assign w_cross = c_CR_W'(r_a2_lh) + c_CR_W'(r_a2_hl);
    assign w_low   = c_LO_W'(r_a3_ll) + (c_LO_W'(r_a3_cross) << SPLIT);
    assign w_full  = P_W'(r_a4_low) + (P_W'(r_a4_hh) << (2 * SPLIT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a1_a     <= '0;
            r_a1_b     <= '0;
            r_a2_ll    <= '0;
            r_a2_lh    <= '0;
            r_a2_hl    <= '0;
            r_a2_hh    <= '0;
            r_a3_ll    <= '0;
            r_a3_cross <= '0;
            r_a3_hh    <= '0;
            r_a4_low   <= '0;
            r_a4_hh    <= '0;
            r_a5_full  <= '0;
            r_a6_out   <= '0;
        end else begin
            r_a1_a     <= MUL_aa_a0;
            r_a1_b     <= MUL_bb_a0;
            r_a2_ll    <= w_pp_ll;
            r_a2_lh    <= w_pp_lh;
            r_a2_hl    <= w_pp_hl;
            r_a2_hh    <= w_pp_hh;
            r_a3_ll    <= r_a2_ll;
            r_a3_cross <= w_cross;
            r_a3_hh    <= r_a2_hh;
            r_a4_low   <= w_low;
            r_a4_hh    <= r_a3_hh;
            r_a5_full  <= w_full;
            r_a6_out   <= r_a5_full;
        end
    end

    assign MUL_mm_a6 = r_a6_out;

endmodule

`default_nettype wire

// File: tb/tb_fpga_mul35_pipe.sv
// ============================================================================
// Module   : tb_fpga_mul35_pipe
// Purpose  : Scoreboard bench for fpga_mul35_pipe against a plain 70-bit
//            multiply reference, with asynchronous reset pulses mid-stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpga_mul35_pipe;

    typedef struct {
        int unsigned  sedge;
        logic [69:0]  prod;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [34:0] aa;
    logic [34:0] bb;
    logic [69:0] mm;

    exp_t        exp_q[$];
    int unsigned edge_cnt = 0;
    int          n_vec    = 0;
    int          n_cmp    = 0;
    int          n_fail   = 0;
    bit          done     = 0;

    fpga_mul35_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .MUL_aa_a0 (aa),
        .MUL_bb_a0 (bb),
        .MUL_mm_a6 (mm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [69:0] ref_mul(input logic [34:0] a, input logic [34:0] b);
        logic [69:0] x;
        logic [69:0] y;
        x = {35'd0, a};
        y = {35'd0, b};
        return x * y;
    endfunction

    function automatic logic [34:0] rand35();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        case ($urandom_range(15, 0))
            0:       return '0;
            1:       return '1;
            2:       return 35'h3_FFFF;
            3:       return 35'h4_0000;
            default: return t[34:0];
        endcase
    endfunction

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: the product of operands sampled at edge s is visible just after edge s+5
    always @(posedge clk) begin
        edge_cnt = edge_cnt + 1;
        #1;
        if (!done) begin
            if (reset) begin
                check("reset_hold", mm, 70'd0);
            end else if (exp_q.size() != 0 && exp_q[0].sedge + 5 <= edge_cnt) begin
                if (exp_q[0].sedge + 5 == edge_cnt)
                    check("product", mm, exp_q[0].prod);
                else
                    check("overdue", 70'(exp_q[0].sedge), 70'(edge_cnt));
                void'(exp_q.pop_front());
            end else begin
                check("bubble", mm, 70'd0);
            end
        end
    end

    task automatic drive(input logic [34:0] a, input logic [34:0] b, input logic [69:0] exp);
        @(negedge clk);
        aa = a;
        bb = b;
        n_vec++;
        if (!reset) exp_q.push_back('{edge_cnt + 1, exp});
    endtask

    task automatic drive_rand();
        logic [34:0] a;
        logic [34:0] b;
        a = rand35();
        b = rand35();
        drive(a, b, ref_mul(a, b));
    endtask

    // Asynchronous reset between edges; release at a negedge with zero operands
    task automatic reset_pulse(input int hold);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_clear", mm, 70'd0);
        exp_q.delete();
        repeat (hold) begin
            @(negedge clk);
            aa = rand35();
            bb = rand35();
        end
        @(negedge clk);
        reset = 1'b0;
        aa = '0;
        bb = '0;
        exp_q.push_back('{edge_cnt + 1, 70'd0});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        aa = rand35();
        bb = rand35();
        repeat (4) begin
            @(negedge clk);
            aa = rand35();
            bb = rand35();
        end
        @(negedge clk);
        reset = 1'b0;
        aa = '0;
        bb = '0;
        exp_q.push_back('{edge_cnt + 1, 70'd0});

        drive(35'd1, 35'd1, 70'd1);
        repeat (7) drive('0, '0, 70'd0);

        drive(35'h7_FFFF_FFFF, 35'h7_FFFF_FFFF, 70'h3F_FFFF_FFF0_0000_0001);
        drive(35'h3_FFFF,      35'h4_0000,      70'hF_FFFC_0000);
        drive(35'h4_0000_0000, 35'd2,           70'h8_0000_0000);
        drive(35'h0_0000_0000, 35'h7_FFFF_FFFF, 70'd0);

        drive(35'd2,           35'd3,   70'd6);
        drive(35'd5,           35'd7,   70'd35);
        drive(35'h1_2345_6789, 35'd0,   70'd0);
        drive(35'h1_0000_0000, 35'h10,  70'h10_0000_0000);
        repeat (3) drive_rand();

        reset_pulse(2);
        repeat (6) drive_rand();

        for (int i = 0; i < 10000; i++) begin
            drive_rand();
            if (i % 2500 == 1234) reset_pulse(1 + (i % 3));
        end

        @(negedge clk);
        aa = '0;
        bb = '0;
        begin
            int budget;
            budget = 20;
            while (exp_q.size() != 0 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            if (exp_q.size() != 0) check("drain", 70'(exp_q.size()), 70'd0);
        end
        repeat (2) @(negedge clk);
        done = 1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
